// File: rtl/cmsdk_ahb_addr_decoder_defslv_pkg.sv
// AHB address decoder with default slave: shared types.
// Transfer/response encodings and default-slave states.
package cmsdk_ahb_addr_decoder_defslv_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam int NPORT = 9;

   typedef enum logic [1:0] {
      ST_OK   = 2'b00,
      ST_ERR1 = 2'b01,
      ST_ERR2 = 2'b10
   } defslv_state_t;

   function automatic logic port_hit(
      input logic        en,
      input logic [31:0] addr,
      input logic [31:0] base,
      input logic [31:0] mask
   );
      return en && ((addr & mask) == base);
   endfunction

endpackage

// File: rtl/cmsdk_ahb_addr_decoder_defslv_if.sv
// Address-phase bus bundle between the AHB master side
// and the decoder/default slave.
interface cmsdk_ahb_addr_decoder_defslv_if #(
   parameter int DW = 32
);
   logic [31:0]   HADDR;
   logic [1:0]    HTRANS;
   logic          HREADY;
   logic          HSEL0;
   logic          HSEL1;
   logic          HSEL2;
   logic          HSEL3;
   logic          HSEL4;
   logic          HSEL5;
   logic          HSEL6;
   logic          HSEL7;
   logic          HSEL8;
   logic          HSELDEF;
   logic          HREADYOUTDEF;
   logic          HRESPDEF;
   logic [DW-1:0] HRDATADEF;

   modport master (
      output HADDR, HTRANS, HREADY,
      input  HSEL0, HSEL1, HSEL2, HSEL3, HSEL4,
      input  HSEL5, HSEL6, HSEL7, HSEL8, HSELDEF,
      input  HREADYOUTDEF, HRESPDEF, HRDATADEF
   );

   modport slave (
      input  HADDR, HTRANS, HREADY,
      output HSEL0, HSEL1, HSEL2, HSEL3, HSEL4,
      output HSEL5, HSEL6, HSEL7, HSEL8, HSELDEF,
      output HREADYOUTDEF, HRESPDEF, HRDATADEF
   );
endinterface

// File: rtl/cmsdk_ahb_default_slave.sv
// Default slave: two-cycle AHB ERROR response for
// accepted transfers to unmapped space.
module cmsdk_ahb_default_slave
   import cmsdk_ahb_addr_decoder_defslv_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          err_acc,
   output logic          HREADYOUT,
   output logic          HRESP,
   output logic [DW-1:0] HRDATA
);

   defslv_state_t state_q;
   defslv_state_t state_d;

   // State register; reset aborts any error in flight.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= ST_OK;
      else          state_q <= state_d;
   end

   // Next state: ERR1 always advances, ERR2 may chain.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_OK:   if (err_acc) state_d = ST_ERR1;
         ST_ERR1: state_d = ST_ERR2;
         ST_ERR2: state_d = err_acc ? ST_ERR1 : ST_OK;
         default: state_d = ST_OK;
      endcase
   end

   // Response decoded purely from registered state.
   always_comb begin
      HREADYOUT = (state_q != ST_ERR1);
      HRESP     = (state_q == ST_OK) ? HRESP_OKAY
                                     : HRESP_ERROR;
   end

   assign HRDATA = '0;

endmodule

// File: rtl/cmsdk_ahb_addr_decoder_defslv.sv
// AHB address decoder for 9 slaves plus default slave,
// with a sticky record of unmapped accesses.
module cmsdk_ahb_addr_decoder_defslv
   import cmsdk_ahb_addr_decoder_defslv_pkg::*;
#(
   parameter int          PORT0_ENABLE = 1,
   parameter int          PORT1_ENABLE = 1,
   parameter int          PORT2_ENABLE = 1,
   parameter int          PORT3_ENABLE = 1,
   parameter int          PORT4_ENABLE = 0,
   parameter int          PORT5_ENABLE = 0,
   parameter int          PORT6_ENABLE = 0,
   parameter int          PORT7_ENABLE = 0,
   parameter int          PORT8_ENABLE = 0,
   parameter logic [31:0] PORT0_BASE = 32'h0000_0000,
   parameter logic [31:0] PORT1_BASE = 32'h1000_0000,
   parameter logic [31:0] PORT2_BASE = 32'h2000_0000,
   parameter logic [31:0] PORT3_BASE = 32'h3000_0000,
   parameter logic [31:0] PORT4_BASE = 32'h4000_0000,
   parameter logic [31:0] PORT5_BASE = 32'h5000_0000,
   parameter logic [31:0] PORT6_BASE = 32'h6000_0000,
   parameter logic [31:0] PORT7_BASE = 32'h7000_0000,
   parameter logic [31:0] PORT8_BASE = 32'h8000_0000,
   parameter logic [31:0] PORT0_MASK = 32'hF000_0000,
   parameter logic [31:0] PORT1_MASK = 32'hF000_0000,
   parameter logic [31:0] PORT2_MASK = 32'hF000_0000,
   parameter logic [31:0] PORT3_MASK = 32'hF000_0000,
   parameter logic [31:0] PORT4_MASK = 32'hF000_0000,
   parameter logic [31:0] PORT5_MASK = 32'hF000_0000,
   parameter logic [31:0] PORT6_MASK = 32'hF000_0000,
   parameter logic [31:0] PORT7_MASK = 32'hF000_0000,
   parameter logic [31:0] PORT8_MASK = 32'hF000_0000,
   parameter int          DW   = 32,
   parameter int          CNTW = 8
) (
   input  logic            HCLK,
   input  logic            HRESETn,
   input  logic            ERRCLR,
   cmsdk_ahb_addr_decoder_defslv_if.slave bus,
   output logic            ERRVALID,
   output logic [31:0]     ERRADDR,
   output logic [CNTW-1:0] ERRCNT
);

   localparam logic [NPORT-1:0] EN = {
      PORT8_ENABLE != 0, PORT7_ENABLE != 0,
      PORT6_ENABLE != 0, PORT5_ENABLE != 0,
      PORT4_ENABLE != 0, PORT3_ENABLE != 0,
      PORT2_ENABLE != 0, PORT1_ENABLE != 0,
      PORT0_ENABLE != 0
   };

   localparam logic [NPORT*32-1:0] BASES = {
      PORT8_BASE, PORT7_BASE, PORT6_BASE,
      PORT5_BASE, PORT4_BASE, PORT3_BASE,
      PORT2_BASE, PORT1_BASE, PORT0_BASE
   };

   localparam logic [NPORT*32-1:0] MASKS = {
      PORT8_MASK, PORT7_MASK, PORT6_MASK,
      PORT5_MASK, PORT4_MASK, PORT3_MASK,
      PORT2_MASK, PORT1_MASK, PORT0_MASK
   };

   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic [NPORT-1:0] match;
   logic [NPORT-1:0] sel;
   logic             sel_def;
   logic             err_acc;
   logic             unused_htrans0;

   logic             valid_d;
   logic [31:0]      addr_d;
   logic [CNTW-1:0]  cnt_d;

   // Per-port address match against masked base.
   always_comb begin
      match = '0;
      for (int k = 0; k < NPORT; k++) begin
         match[k] = port_hit(EN[k], bus.HADDR,
                             BASES[k*32 +: 32],
                             MASKS[k*32 +: 32]);
      end
   end

   // Lowest index wins on overlap; isolate lowest set bit.
   always_comb begin
      sel     = match & (~match + NPORT'(1));
      sel_def = ~|match;
   end

   assign bus.HSEL0   = sel[0];
   assign bus.HSEL1   = sel[1];
   assign bus.HSEL2   = sel[2];
   assign bus.HSEL3   = sel[3];
   assign bus.HSEL4   = sel[4];
   assign bus.HSEL5   = sel[5];
   assign bus.HSEL6   = sel[6];
   assign bus.HSEL7   = sel[7];
   assign bus.HSEL8   = sel[8];
   assign bus.HSELDEF = sel_def;

   assign err_acc = bus.HREADY & sel_def
                  & bus.HTRANS[1];

   assign unused_htrans0 = bus.HTRANS[0];

   cmsdk_ahb_default_slave #(
      .DW (DW)
   ) u_defslv (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .err_acc   (err_acc),
      .HREADYOUT (bus.HREADYOUTDEF),
      .HRESP     (bus.HRESPDEF),
      .HRDATA    (bus.HRDATADEF)
   );

   // Record update: clear first, then fold in new error.
   always_comb begin
      valid_d = ERRVALID;
      addr_d  = ERRADDR;
      cnt_d   = ERRCNT;
      if (ERRCLR) begin
         valid_d = 1'b0;
         addr_d  = '0;
         cnt_d   = '0;
      end
      if (err_acc) begin
         if (!valid_d) begin
            valid_d = 1'b1;
            addr_d  = bus.HADDR;
         end
         if (cnt_d != CNT_MAX) cnt_d = cnt_d + CNTW'(1);
      end
   end

   // Debug record registers.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ERRVALID <= 1'b0;
         ERRADDR  <= '0;
         ERRCNT   <= '0;
      end else begin
         ERRVALID <= valid_d;
         ERRADDR  <= addr_d;
         ERRCNT   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_cmsdk_ahb_addr_decoder_defslv.sv
// Testbench for the AHB address decoder / default slave.
// Directed table, corner sequences and random vs. model.
module tb_cmsdk_ahb_addr_decoder_defslv;

   logic        HCLK;
   logic        HRESETn;
   logic        errclr;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hready;

   logic        ERRVALID;
   logic [31:0] ERRADDR;
   logic [7:0]  ERRCNT;
   logic        o_valid;
   logic [31:0] o_addr;
   logic [7:0]  o_cnt;

   int checks = 0;
   int errs   = 0;

   cmsdk_ahb_addr_decoder_defslv_if bus ();
   cmsdk_ahb_addr_decoder_defslv_if bus2 ();

   assign bus.HADDR   = haddr;
   assign bus.HTRANS  = htrans;
   assign bus.HREADY  = hready;
   assign bus2.HADDR  = haddr;
   assign bus2.HTRANS = 2'b00;
   assign bus2.HREADY = 1'b1;

   cmsdk_ahb_addr_decoder_defslv dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .ERRCLR   (errclr),
      .bus      (bus),
      .ERRVALID (ERRVALID),
      .ERRADDR  (ERRADDR),
      .ERRCNT   (ERRCNT)
   );

   cmsdk_ahb_addr_decoder_defslv #(
      .PORT0_MASK (32'h0),
      .PORT1_MASK (32'h0),
      .PORT1_BASE (32'h0)
   ) u_ovl (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .ERRCLR   (1'b0),
      .bus      (bus2),
      .ERRVALID (o_valid),
      .ERRADDR  (o_addr),
      .ERRCNT   (o_cnt)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   wire [9:0] sel_vec = {
      bus.HSELDEF, bus.HSEL8, bus.HSEL7, bus.HSEL6,
      bus.HSEL5, bus.HSEL4, bus.HSEL3, bus.HSEL2,
      bus.HSEL1, bus.HSEL0};

   wire [9:0] ovl_vec = {
      bus2.HSELDEF, bus2.HSEL8, bus2.HSEL7, bus2.HSEL6,
      bus2.HSEL5, bus2.HSEL4, bus2.HSEL3, bus2.HSEL2,
      bus2.HSEL1, bus2.HSEL0};

   // Reference model state.
   logic [1:0]  m_q[$];
   logic        m_valid;
   logic [31:0] m_addr;
   int          m_cnt;
   int          m_idx;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  trans;
      logic        clr;
      logic        hrok;
      int          sel;
      logic        rdy;
      logic        resp;
      logic        valid;
      logic [31:0] eaddr;
      logic [7:0]  cnt;
   } vec_t;

   vec_t tbl[19];

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   function automatic int ref_sel(input logic [31:0] a);
      for (int k = 0; k < 9; k++) begin
         logic [31:0] base;
         base = 32'(k) << 28;
         if (k < 4 && (a & 32'hF000_0000) == base)
            return k;
      end
      return 9;
   endfunction

   function automatic logic [1:0] cur_resp();
      if (m_q.size() != 0) return m_q[0];
      return 2'b10;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_valid = 1'b0;
      m_addr  = '0;
      m_cnt   = 0;
   endtask

   // Drive inputs at negedge, check outputs 1ns later.
   task automatic apply(input logic [31:0] a,
                        input logic [1:0] t,
                        input logic clr,
                        input logic hrok);
      logic [1:0] r;
      r      = cur_resp();
      haddr  = a;
      htrans = t;
      errclr = clr;
      hready = r[1] & hrok;
      m_idx  = ref_sel(a);
      #1;
      chk("hsel", 64'(sel_vec), 64'(10'b1 << m_idx));
      chk("hreadyout", 64'(bus.HREADYOUTDEF), 64'(r[1]));
      chk("hresp", 64'(bus.HRESPDEF), 64'(r[0]));
      chk("hrdata", 64'(bus.HRDATADEF), 64'(0));
      chk("errvalid", 64'(ERRVALID), 64'(m_valid));
      chk("erraddr", 64'(ERRADDR), 64'(m_addr));
      chk("errcnt", 64'(ERRCNT), 64'(m_cnt));
   endtask

   // Clock edge, then update the model.
   task automatic advance();
      logic acc;
      @(posedge HCLK);
      acc = hready && m_idx == 9 && htrans[1];
      if (m_q.size() != 0) void'(m_q.pop_front());
      if (acc) begin
         m_q.push_back(2'b01);
         m_q.push_back(2'b11);
      end
      if (errclr) begin
         m_valid = 1'b0;
         m_addr  = '0;
         m_cnt   = 0;
      end
      if (acc) begin
         if (!m_valid) begin
            m_valid = 1'b1;
            m_addr  = haddr;
         end
         if (m_cnt < 255) m_cnt++;
      end
      @(negedge HCLK);
   endtask

   task automatic row(input int i,
                      input logic [31:0] a,
                      input logic [1:0] t,
                      input logic c, input logic h,
                      input int s, input logic rd,
                      input logic rs, input logic v,
                      input logic [31:0] ea,
                      input logic [7:0] cn);
      tbl[i] = '{a, t, c, h, s, rd, rs, v, ea, cn};
   endtask

   localparam logic [1:0] ID = 2'b00;
   localparam logic [1:0] BS = 2'b01;
   localparam logic [1:0] NS = 2'b10;
   localparam logic [1:0] SQ = 2'b11;
   localparam logic [31:0] A8 = 32'h8000_0000;
   localparam logic [31:0] A9 = 32'h9000_0000;
   localparam logic [31:0] AA = 32'hA000_0000;

   initial begin
      row(0,  32'h1000_0004, NS, 0, 1, 1, 1, 0, 0, 0, 0);
      row(1,  A8, NS, 0, 1, 9, 1, 0, 0, 0,  0);
      row(2,  0,  ID, 0, 1, 0, 0, 1, 1, A8, 1);
      row(3,  0,  ID, 0, 1, 0, 1, 1, 1, A8, 1);
      row(4,  0,  ID, 0, 1, 0, 1, 0, 1, A8, 1);
      row(5,  A8, NS, 0, 1, 9, 1, 0, 1, A8, 1);
      row(6,  A9, NS, 0, 1, 9, 0, 1, 1, A8, 2);
      row(7,  A9, NS, 0, 1, 9, 1, 1, 1, A8, 2);
      row(8,  0,  ID, 0, 1, 0, 0, 1, 1, A8, 3);
      row(9,  0,  ID, 0, 1, 0, 1, 1, 1, A8, 3);
      row(10, A8, ID, 0, 1, 9, 1, 0, 1, A8, 3);
      row(11, A8, NS, 0, 0, 9, 1, 0, 1, A8, 3);
      row(12, AA, NS, 1, 1, 9, 1, 0, 1, A8, 3);
      row(13, 0,  ID, 0, 1, 0, 0, 1, 1, AA, 1);
      row(14, 0,  ID, 0, 1, 0, 1, 1, 1, AA, 1);
      row(15, 32'h3000_0010, SQ, 0, 1, 3,
          1, 0, 1, AA, 1);
      row(16, 32'h4000_0000, BS, 0, 1, 9,
          1, 0, 1, AA, 1);
      row(17, 0,  ID, 1, 1, 0, 1, 0, 1, AA, 1);
      row(18, 0,  ID, 0, 1, 0, 1, 0, 0, 0,  0);

      haddr   = '0;
      htrans  = ID;
      errclr  = 1'b0;
      hready  = 1'b1;
      HRESETn = 1'b0;
      model_reset();
      @(negedge HCLK);
      #1;
      chk("rst_hreadyout", 64'(bus.HREADYOUTDEF), 1);
      chk("rst_hresp", 64'(bus.HRESPDEF), 0);
      chk("rst_errvalid", 64'(ERRVALID), 0);
      chk("rst_errcnt", 64'(ERRCNT), 0);
      @(negedge HCLK);
      HRESETn = 1'b1;

      // Directed table
      for (int i = 0; i < 19; i++) begin
         apply(tbl[i].addr, tbl[i].trans,
               tbl[i].clr, tbl[i].hrok);
         chk($sformatf("t%0d_sel", i), 64'(sel_vec),
             64'(10'b1 << tbl[i].sel));
         chk($sformatf("t%0d_rdy", i),
             64'(bus.HREADYOUTDEF), 64'(tbl[i].rdy));
         chk($sformatf("t%0d_resp", i),
             64'(bus.HRESPDEF), 64'(tbl[i].resp));
         chk($sformatf("t%0d_valid", i),
             64'(ERRVALID), 64'(tbl[i].valid));
         chk($sformatf("t%0d_eaddr", i),
             64'(ERRADDR), 64'(tbl[i].eaddr));
         chk($sformatf("t%0d_cnt", i),
             64'(ERRCNT), 64'(tbl[i].cnt));
         chk($sformatf("t%0d_ovl", i),
             64'(ovl_vec), 64'(10'b1));
         advance();
      end

      // Counter saturation
      for (int i = 0; i < 600; i++) begin
         apply(A8, NS, 0, 1);
         advance();
      end
      apply(0, ID, 0, 1);
      chk("sat_cnt", 64'(ERRCNT), 64'(8'hFF));
      advance();
      apply(0, ID, 0, 1);
      advance();
      apply(0, ID, 0, 1);
      advance();

      // Asynchronous reset while in ERR1
      apply(A8, NS, 0, 1);
      advance();
      #1;
      chk("err1_hreadyout", 64'(bus.HREADYOUTDEF), 0);
      #1;
      HRESETn = 1'b0;
      #1;
      model_reset();
      chk("arst_hreadyout", 64'(bus.HREADYOUTDEF), 1);
      chk("arst_hresp", 64'(bus.HRESPDEF), 0);
      chk("arst_errvalid", 64'(ERRVALID), 0);
      chk("arst_errcnt", 64'(ERRCNT), 0);
      @(negedge HCLK);
      HRESETn = 1'b1;

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] a;
         logic [3:0]  top;
         top = 4'($urandom_range(0, 15));
         a   = {top, 28'($urandom)};
         apply(a, 2'($urandom),
               $urandom_range(0, 15) == 0,
               $urandom_range(0, 7) != 0);
         advance();
      end

      $display("Result: errors=%0d of %0d checks",
               errs, checks);
      $finish;
   end

endmodule

// File: doc/cmsdk_ahb_addr_decoder_defslv.md
Name: cmsdk_ahb_addr_decoder_defslv

Overview:
- Address-phase counterpart of the AHB slave response multiplexer.
- Decodes HADDR into one-hot HSEL0..HSEL8 for up to 9 mapped slaves, plus HSELDEF for unmapped addresses.
- Contains the default slave, which sits on mux port 9 and returns the two-cycle AHB ERROR response for active transfers to unmapped space.
- Holds a sticky debug record of the first unmapped-access address and a saturating error count.

Parameters:
- PORT0_ENABLE..PORT8_ENABLE, default 1 for ports 0-3 and 0 for ports 4-8: port k takes part in decode only when nonzero.
- PORT0_BASE..PORT8_BASE, default 32'h0000_0000 + k*32'h1000_0000: match value applied after masking.
- PORT0_MASK..PORT8_MASK, default 32'hF000_0000: address bits compared for port k.
- DW, default 32: HRDATADEF width.
- CNTW, default 8: ERRCNT width.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- HADDR  in  32  address-phase address
- HTRANS  in  2  transfer type; bit1=1 means NONSEQ/SEQ
- HREADY  in  1  bus HREADY, from the mux HREADYOUT
- ERRCLR  in  1  synchronous clear of the debug record
- HSEL0..HSEL8  out  1 each  slave selects, combinational
- HSELDEF  out  1  default-slave select (mux port 9 HSEL), combinational
- HREADYOUTDEF  out  1  default-slave HREADYOUT
- HRESPDEF  out  1  default-slave HRESP
- HRDATADEF  out  DW  default-slave read data, constant 0
- ERRVALID  out  1  debug record holds a captured error
- ERRADDR  out  32  address of the first unmapped active transfer since clear
- ERRCNT  out  CNTW  saturating count of unmapped active transfers

Behaviour:
- Decode, combinational:
  - match_k = PORTk_ENABLE!=0 && (HADDR & PORTk_MASK)==PORTk_BASE.
  - On overlap, the lowest index wins, so HSEL0..8 is always zero-or-one-hot.
  - HSELDEF = ~|match. Exactly one of HSEL0..8/HSELDEF is high every cycle, independent of HTRANS and HREADY.
- Accept condition: err_acc = HREADY & HSELDEF & HTRANS[1]. IDLE/BUSY to unmapped space gives a zero-wait OKAY.
- Default-slave FSM, 3 states:
  - OK: HREADYOUTDEF=1, HRESPDEF=0. err_acc -> ERR1; otherwise stay.
  - ERR1: HREADYOUTDEF=0, HRESPDEF=1. Unconditional -> ERR2. HREADY is low here because the mux forwards 0.
  - ERR2: HREADYOUTDEF=1, HRESPDEF=1. err_acc (back-to-back error) -> ERR1; else -> OK.
- Outputs are decoded from registered state; no combinational input-to-output path on the response side.
- Reset: state=OK, so HREADYOUTDEF=1 and HRESPDEF=0. ERRVALID=0, ERRADDR=0, ERRCNT=0. HRDATADEF=0 at all times.
- A reset asserted mid-ERR1/ERR2 returns to OK immediately (asynchronous).
- Debug record, updated on the HCLK edge:
  - On err_acc: ERRCNT increments, saturating at all-ones. If ERRVALID=0, ERRADDR<=HADDR and ERRVALID<=1; later errors leave ERRADDR unchanged.
  - On ERRCLR: ERRVALID<=0, ERRCNT<=0, ERRADDR<=0.
  - ERRCLR and err_acc in the same cycle: the clear applies first, then the new error, giving ERRVALID=1, ERRCNT=1, ERRADDR=HADDR.
- An HTRANS active while HREADY=0 is not sampled: no FSM or counter effect.

Decomposition:
- Shared package: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HRESP OKAY/ERROR constants, FSM state encoding (OK=2'b00, ERR1=2'b01, ERR2=2'b10).
- One natural sub-module: cmsdk_ahb_default_slave (FSM, HREADYOUT/HRESP/HRDATA). The decoder and debug record stay in the top.

Test Plan:
- Reset, then NONSEQ HADDR=32'h1000_0004 with HREADY=1 -> HSEL1=1, others 0; HREADYOUTDEF=1, HRESPDEF=0, ERRCNT=0.
- NONSEQ HADDR=32'h8000_0000 (unmapped) -> HSELDEF=1; the next two cycles show HREADYOUTDEF/HRESPDEF = 0/1 then 1/1; the third returns to 1/0. ERRVALID=1, ERRADDR=32'h8000_0000, ERRCNT=1.
- Back-to-back NONSEQ to 32'h8000_0000 then 32'h9000_0000, the second accepted in ERR2 -> ERR1 follows directly. ERRCNT=2, ERRADDR stays 32'h8000_0000.
- IDLE to 32'h8000_0000 -> HSELDEF=1 but the FSM stays OK and ERRCNT is unchanged. Set PORT0_MASK=PORT1_MASK=0 (overlapping map) -> only HSEL0=1.
- 256 unmapped NONSEQs with CNTW=8 -> ERRCNT=8'hFF after the 255th and stays there. ERRCLR in the same cycle as an err_acc to 32'hA000_0000 -> ERRCNT=1, ERRADDR=32'hA000_0000.
- HRESETn asserted while in ERR1 -> HREADYOUTDEF=1 and HRESPDEF=0 immediately. ERRVALID=0 and ERRCNT=0.
